uart_rx_multi_mode: RTL and testbench

- Parametrised successor UART receiver for the UART subsystem.
- Supports runtime-selectable data length (5..DATA_WIDTH), 1 or 2 stop bits, and optional even/odd parity.
- Resolves each bit by 3-sample majority vote and rejects false (glitch) start bits.
- Received frames are buffered in a small FIFO, each entry carrying its own error flags, and drained through a valid/ready handshake.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_fifo.sv | 53 +++++
 rtl/uart_rx_multi_mode.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_rx_multi_mode.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the multi-mode UART receiver.
// State encodings, config clamp limits, FIFO entry layout helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_PUSH   = 3'd5
    } rx_state_t;

    localparam int MIN_PRESCALE = 4;
    localparam int MIN_DATA_LEN = 5;

    // Entry layout: {frame_error, parity_error, data[DATA_WIDTH-1:0]}
    localparam int ENTRY_DATA_LSB = 0;

    function automatic int entry_pe_bit(input int data_width);
        return data_width;
    endfunction

    function automatic int entry_fe_bit(input int data_width);
        return data_width + 1;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through frame FIFO; a push while full is refused unless a
// pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_multi_mode.sv
// Multi-mode UART receiver: 3-sample majority bits, per-frame config latch,
// FWFT frame FIFO. Break detection is built when UART_RX_BREAK_DETECT_EN is defined.
//
// state     | meaning
// ST_IDLE   | waiting for a synchronised falling edge (or break re-arm)
// ST_START  | validating the start bit, false start returns to idle
// ST_DATA   | shifting data bits LSB first
// ST_PARITY | checking the parity bit
// ST_STOP   | checking one or two stop bits
// ST_PUSH   | single cycle: write entry to FIFO (or signal a break)
module uart_rx_multi_mode
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               parity_enable,
    input  logic                               parity_type,
    input  logic                               stop_bits_2,
    input  logic [$clog2(DATA_WIDTH+1)-1:0]    data_length,
    input  logic [PRESCALE_WIDTH-1:0]          prescale,
    input  logic                               serial_data_in,
    input  logic                               rx_ready,
    output logic                               rx_valid,
    output logic [DATA_WIDTH-1:0]              parallel_data,
    output logic                               parity_error,
    output logic                               frame_error,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               overrun,
    output logic                               break_detect
);

    localparam int LW     = $clog2(DATA_WIDTH + 1);
    localparam int PW     = PRESCALE_WIDTH;
    localparam int EW     = DATA_WIDTH + 2;
    localparam int PE_BIT = entry_pe_bit(DATA_WIDTH);
    localparam int FE_BIT = entry_fe_bit(DATA_WIDTH);

    logic                  sync1, sync2, rx_prev;
    rx_state_t             state;
    logic [PW-1:0]         edge_cnt, p_lat, p_eff, mid;
    logic [LW-1:0]         bit_cnt, len_lat, len_eff;
    logic                  pe_lat, pt_lat, s2_lat, stop_idx;
    logic                  s0, s1, maj;
    logic                  at_s0, at_s1, at_eval, at_wrap;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  perr, ferr;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EW-1:0]         fifo_wdata, fifo_rdata;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                  seen_one, brk, rearm;
`endif

    always_comb begin
        p_eff = prescale;
        if (prescale < PW'(MIN_PRESCALE)) p_eff = PW'(MIN_PRESCALE);
        len_eff = data_length;
        if (data_length < LW'(MIN_DATA_LEN))    len_eff = LW'(MIN_DATA_LEN);
        else if (data_length > LW'(DATA_WIDTH)) len_eff = LW'(DATA_WIDTH);
    end

    assign mid     = p_lat >> 1;
    assign at_s0   = (edge_cnt == mid - PW'(1));
    assign at_s1   = (edge_cnt == mid);
    assign at_eval = (edge_cnt == mid + PW'(1));
    assign at_wrap = (edge_cnt == p_lat - PW'(1));
    assign maj     = majority3(s0, s1, sync2);

`ifdef UART_RX_BREAK_DETECT_EN
    assign fifo_push = (state == ST_PUSH) && !brk;
`else
    assign fifo_push = (state == ST_PUSH);
    assign break_detect = 1'b0;
`endif
    assign fifo_pop = rx_valid && rx_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            rx_prev  <= 1'b1;
            state    <= ST_IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            p_lat    <= PW'(MIN_PRESCALE);
            len_lat  <= LW'(MIN_DATA_LEN);
            pe_lat   <= 1'b0;
            pt_lat   <= 1'b0;
            s2_lat   <= 1'b0;
            stop_idx <= 1'b0;
            s0       <= 1'b0;
            s1       <= 1'b0;
            data_reg <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            overrun  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            seen_one     <= 1'b0;
            brk          <= 1'b0;
            rearm        <= 1'b0;
            break_detect <= 1'b0;
`endif
        end else begin
            sync1   <= serial_data_in;
            sync2   <= sync1;
            rx_prev <= sync2;
            overrun <= fifo_push && fifo_full && !fifo_pop;
`ifdef UART_RX_BREAK_DETECT_EN
            break_detect <= 1'b0;
`endif
            if (at_s0) s0 <= sync2;
            if (at_s1) s1 <= sync2;
            if (state != ST_IDLE && state != ST_PUSH)
                edge_cnt <= at_wrap ? '0 : edge_cnt + PW'(1);

            case (state)
                ST_IDLE: begin
`ifdef UART_RX_BREAK_DETECT_EN
                    // After a break the line must stay high a full bit before re-arming.
                    if (rearm) begin
                        if (!sync2)                         edge_cnt <= '0;
                        else if (edge_cnt == p_lat - PW'(1)) rearm   <= 1'b0;
                        else                                edge_cnt <= edge_cnt + PW'(1);
                    end else
`endif
                    if (rx_prev && !sync2) begin
                        state    <= ST_START;
                        edge_cnt <= '0;
                        bit_cnt  <= '0;
                        stop_idx <= 1'b0;
                        data_reg <= '0;
                        perr     <= 1'b0;
                        ferr     <= 1'b0;
                        p_lat    <= p_eff;
                        len_lat  <= len_eff;
                        pe_lat   <= parity_enable;
                        pt_lat   <= parity_type;
                        s2_lat   <= stop_bits_2;
`ifdef UART_RX_BREAK_DETECT_EN
                        seen_one <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (at_eval && maj) state <= ST_IDLE;
                    else if (at_wrap)   state <= ST_DATA;
                end
                ST_DATA: begin
                    if (at_eval) begin
                        data_reg <= data_reg | (DATA_WIDTH'(maj) << bit_cnt);
`ifdef UART_RX_BREAK_DETECT_EN
                        seen_one <= seen_one | maj;
`endif
                    end
                    if (at_wrap) begin
                        if (bit_cnt == len_lat - LW'(1)) state <= pe_lat ? ST_PARITY : ST_STOP;
                        else                             bit_cnt <= bit_cnt + LW'(1);
                    end
                end
                ST_PARITY: begin
                    if (at_eval) begin
                        perr <= maj ^ (^data_reg) ^ pt_lat;
`ifdef UART_RX_BREAK_DETECT_EN
                        seen_one <= seen_one | maj;
`endif
                    end
                    if (at_wrap) state <= ST_STOP;
                end
                ST_STOP: begin
                    if (at_eval) begin
                        if (!maj) ferr <= 1'b1;
                        if (stop_idx || !s2_lat) state <= ST_PUSH;
`ifdef UART_RX_BREAK_DETECT_EN
                        if (!stop_idx && !maj && !seen_one) begin
                            brk   <= 1'b1;
                            state <= ST_PUSH;
                        end
`endif
                    end
                    if (at_wrap) stop_idx <= 1'b1;
                end
                ST_PUSH: begin
                    state <= ST_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                    if (brk) begin
                        brk          <= 1'b0;
                        break_detect <= 1'b1;
                        rearm        <= 1'b1;
                        edge_cnt     <= '0;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        fifo_wdata = '0;
        fifo_wdata[ENTRY_DATA_LSB +: DATA_WIDTH] = data_reg;
        fifo_wdata[PE_BIT] = perr;
        fifo_wdata[FE_BIT] = ferr;
    end

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rx_valid      = !fifo_empty;
    assign parallel_data = fifo_rdata[ENTRY_DATA_LSB +: DATA_WIDTH];
    assign parity_error  = fifo_rdata[PE_BIT];
    assign frame_error   = fifo_rdata[FE_BIT];

endmodule

// File: tb/tb_uart_rx_multi_mode.sv
// Directed bench for uart_rx_multi_mode; break scenario follows UART_RX_BREAK_DETECT_EN.
module tb_uart_rx_multi_mode;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       parity_enable = 1'b0;
    logic       parity_type = 1'b0;
    logic       stop_bits_2 = 1'b0;
    logic [3:0] data_length = 4'd8;
    logic [5:0] prescale = 6'd8;
    logic       serial_data_in = 1'b1;
    logic       rx_ready = 1'b0;
    logic       rx_valid;
    logic [7:0] parallel_data;
    logic       parity_error;
    logic       frame_error;
    logic [2:0] fifo_level;
    logic       overrun;
    logic       break_detect;

    int pass_cnt = 0;
    int total_cnt = 0;
    int ovr_cnt = 0;
    int brk_cnt = 0;

    uart_rx_multi_mode #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .parity_enable  (parity_enable),
        .parity_type    (parity_type),
        .stop_bits_2    (stop_bits_2),
        .data_length    (data_length),
        .prescale       (prescale),
        .serial_data_in (serial_data_in),
        .rx_ready       (rx_ready),
        .rx_valid       (rx_valid),
        .parallel_data  (parallel_data),
        .parity_error   (parity_error),
        .frame_error    (frame_error),
        .fifo_level     (fifo_level),
        .overrun        (overrun),
        .break_detect   (break_detect)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun === 1'b1)      ovr_cnt++;
        if (break_detect === 1'b1) brk_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

    task automatic set_cfg(input bit pe, input bit pt, input bit s2, input int dl, input int ps);
        parity_enable = pe;
        parity_type   = pt;
        stop_bits_2   = s2;
        data_length   = 4'(dl);
        prescale      = 6'(ps);
    endtask

    task automatic idle(input int n);
        serial_data_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int p, input int nbits, input logic [7:0] data,
                              input bit par_en, input bit par_bit, input bit two_stop,
                              input bit stop1, input bit stop2, input int glitch_idx);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
        if (par_en) bits.push_back(par_bit);
        bits.push_back(stop1);
        if (two_stop) bits.push_back(stop2);
        foreach (bits[i]) begin
            if (i == glitch_idx) begin
                serial_data_in = bits[i];
                repeat (p / 2) @(negedge clk);
                serial_data_in = ~bits[i];
                @(negedge clk);
                serial_data_in = bits[i];
                repeat (p - p / 2 - 1) @(negedge clk);
            end else begin
                serial_data_in = bits[i];
                repeat (p) @(negedge clk);
            end
        end
        serial_data_in = 1'b1;
    endtask

    task automatic wait_valid(input int max_cycles, output int lat);
        lat = 0;
        while (rx_valid !== 1'b1 && lat < max_cycles) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop_entry();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            serial_data_in = i[0];
            @(negedge clk);
        end
        total_cnt++; if (rx_valid !== 1'b0)      $display("FAIL reset_rx_valid: got %0h expected 0", rx_valid); else pass_cnt++;
        total_cnt++; if (parallel_data !== 8'h0) $display("FAIL reset_data: got %0h expected 0", parallel_data); else pass_cnt++;
        total_cnt++; if (parity_error !== 1'b0)  $display("FAIL reset_parity_error: got %0h expected 0", parity_error); else pass_cnt++;
        total_cnt++; if (frame_error !== 1'b0)   $display("FAIL reset_frame_error: got %0h expected 0", frame_error); else pass_cnt++;
        total_cnt++; if (fifo_level !== 3'd0)    $display("FAIL reset_level: got %0h expected 0", fifo_level); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0)       $display("FAIL reset_overrun: got %0h expected 0", overrun); else pass_cnt++;
        total_cnt++; if (break_detect !== 1'b0)  $display("FAIL reset_break: got %0h expected 0", break_detect); else pass_cnt++;
        rx_ready = 1'b0;
        reset = 1'b1;
        set_cfg(0, 0, 0, 8, 8);
        idle(16);
        // partial frame then reset: start, bit0=1, bit1=0, then reset
        serial_data_in = 1'b0; repeat (8) @(negedge clk);
        serial_data_in = 1'b1; repeat (8) @(negedge clk);
        serial_data_in = 1'b0; repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(200);
        total_cnt++; if (rx_valid !== 1'b0)   $display("FAIL midframe_reset_valid: got %0h expected 0", rx_valid); else pass_cnt++;
        total_cnt++; if (fifo_level !== 3'd0) $display("FAIL midframe_reset_level: got %0h expected 0", fifo_level); else pass_cnt++;
    endtask

    task automatic test_basic_even_parity();
        int lat;
        set_cfg(1, 0, 0, 8, 8);
        idle(16);
        send_frame(8, 8, 8'h6A, 1, 0, 0, 1, 1, -1);
        wait_valid(40, lat);
        total_cnt++; if (lat !== 2)               $display("FAIL basic_latency: got %0d expected 2", lat); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b1)       $display("FAIL basic_valid: got %0h expected 1", rx_valid); else pass_cnt++;
        total_cnt++; if (parallel_data !== 8'h6A) $display("FAIL basic_data: got %0h expected 6a", parallel_data); else pass_cnt++;
        total_cnt++; if (parity_error !== 1'b0)   $display("FAIL basic_parity_error: got %0h expected 0", parity_error); else pass_cnt++;
        total_cnt++; if (frame_error !== 1'b0)    $display("FAIL basic_frame_error: got %0h expected 0", frame_error); else pass_cnt++;
        total_cnt++; if (fifo_level !== 3'd1)     $display("FAIL basic_level: got %0h expected 1", fifo_level); else pass_cnt++;
        pop_entry();
        total_cnt++; if (rx_valid !== 1'b0)       $display("FAIL basic_pop_valid: got %0h expected 0", rx_valid); else pass_cnt++;
    endtask

    task automatic test_two_stop();
        int lat;
        set_cfg(0, 0, 1, 5, 16);
        idle(32);
        send_frame(16, 5, 8'h15, 0, 0, 1, 1, 1, -1);
        wait_valid(64, lat);
        total_cnt++; if (parallel_data !== 8'h15) $display("FAIL twostop_data: got %0h expected 15", parallel_data); else pass_cnt++;
        total_cnt++; if (frame_error !== 1'b0)    $display("FAIL twostop_frame_error: got %0h expected 0", frame_error); else pass_cnt++;
        total_cnt++; if (parity_error !== 1'b0)   $display("FAIL twostop_parity_error: got %0h expected 0", parity_error); else pass_cnt++;
        pop_entry();
        send_frame(16, 5, 8'h15, 0, 0, 1, 1, 0, -1);
        wait_valid(64, lat);
        total_cnt++; if (rx_valid !== 1'b1)       $display("FAIL badstop2_valid: got %0h expected 1", rx_valid); else pass_cnt++;
        total_cnt++; if (parallel_data !== 8'h15) $display("FAIL badstop2_data: got %0h expected 15", parallel_data); else pass_cnt++;
        total_cnt++; if (frame_error !== 1'b1)    $display("FAIL badstop2_frame_error: got %0h expected 1", frame_error); else pass_cnt++;
        pop_entry();
    endtask

    task automatic test_odd_parity_error();
        int lat;
        set_cfg(1, 1, 0, 8, 8);
        idle(16);
        // 0xF7 has seven ones: correct odd parity bit is 0, send 1
        send_frame(8, 8, 8'hF7, 1, 1, 0, 1, 1, -1);
        wait_valid(40, lat);
        total_cnt++; if (parallel_data !== 8'hF7) $display("FAIL oddpar_data: got %0h expected f7", parallel_data); else pass_cnt++;
        total_cnt++; if (parity_error !== 1'b1)   $display("FAIL oddpar_parity_error: got %0h expected 1", parity_error); else pass_cnt++;
        total_cnt++; if (frame_error !== 1'b0)    $display("FAIL oddpar_frame_error: got %0h expected 0", frame_error); else pass_cnt++;
        pop_entry();
    endtask

    task automatic test_false_start_and_glitch();
        int lat;
        set_cfg(0, 0, 0, 8, 8);
        idle(16);
        serial_data_in = 1'b0;
        repeat (2) @(negedge clk);
        idle(40);
        total_cnt++; if (rx_valid !== 1'b0)   $display("FAIL falsestart_valid: got %0h expected 0", rx_valid); else pass_cnt++;
        total_cnt++; if (fifo_level !== 3'd0) $display("FAIL falsestart_level: got %0h expected 0", fifo_level); else pass_cnt++;
        send_frame(8, 8, 8'h3C, 0, 0, 0, 1, 1, -1);
        wait_valid(40, lat);
        total_cnt++; if (parallel_data !== 8'h3C) $display("FAIL after_falsestart_data: got %0h expected 3c", parallel_data); else pass_cnt++;
        pop_entry();
        idle(8);
        send_frame(8, 8, 8'hA5, 0, 0, 0, 1, 1, 3);
        wait_valid(40, lat);
        total_cnt++; if (parallel_data !== 8'hA5) $display("FAIL glitch_data: got %0h expected a5", parallel_data); else pass_cnt++;
        pop_entry();
    endtask

    task automatic test_clamp();
        int lat;
        set_cfg(0, 0, 0, 3, 2);
        idle(16);
        send_frame(4, 5, 8'h13, 0, 0, 0, 1, 1, -1);
        wait_valid(40, lat);
        total_cnt++; if (parallel_data !== 8'h13) $display("FAIL clamp_low_data: got %0h expected 13", parallel_data); else pass_cnt++;
        pop_entry();
        set_cfg(0, 0, 0, 15, 8);
        idle(16);
        send_frame(8, 8, 8'hC3, 0, 0, 0, 1, 1, -1);
        wait_valid(40, lat);
        total_cnt++; if (parallel_data !== 8'hC3) $display("FAIL clamp_high_data: got %0h expected c3", parallel_data); else pass_cnt++;
        pop_entry();
    endtask

    task automatic test_back_to_back();
        int ob;
        set_cfg(0, 0, 0, 8, 8);
        idle(16);
        ob = ovr_cnt;
        for (int i = 1; i <= 5; i++) send_frame(8, 8, 8'(i), 0, 0, 0, 1, 1, -1);
        idle(24);
        total_cnt++; if (fifo_level !== 3'd4) $display("FAIL b2b_level: got %0d expected 4", fifo_level); else pass_cnt++;
        total_cnt++; if (ovr_cnt - ob !== 1)  $display("FAIL b2b_overrun_pulses: got %0d expected 1", ovr_cnt - ob); else pass_cnt++;
        for (int i = 1; i <= 4; i++) begin
            total_cnt++; if (rx_valid !== 1'b1)       $display("FAIL drain_valid[%0d]: got %0h expected 1", i, rx_valid); else pass_cnt++;
            total_cnt++; if (parallel_data !== 8'(i)) $display("FAIL drain_data[%0d]: got %0h expected %0h", i, parallel_data, i); else pass_cnt++;
            pop_entry();
        end
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL drain_empty: got %0h expected 0", rx_valid); else pass_cnt++;
    endtask

    task automatic test_break();
        int lat;
        int bb;
        set_cfg(0, 0, 0, 8, 8);
        idle(16);
        bb = brk_cnt;
        serial_data_in = 1'b0;
        repeat (96) @(negedge clk);
        idle(16);
`ifdef UART_RX_BREAK_DETECT_EN
        total_cnt++; if (brk_cnt - bb !== 1)  $display("FAIL break_pulses: got %0d expected 1", brk_cnt - bb); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0)   $display("FAIL break_no_entry: got %0h expected 0", rx_valid); else pass_cnt++;
`else
        total_cnt++; if (brk_cnt - bb !== 0)      $display("FAIL break_pulses: got %0d expected 0", brk_cnt - bb); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b1)       $display("FAIL break_entry_valid: got %0h expected 1", rx_valid); else pass_cnt++;
        total_cnt++; if (parallel_data !== 8'h00) $display("FAIL break_entry_data: got %0h expected 0", parallel_data); else pass_cnt++;
        total_cnt++; if (frame_error !== 1'b1)    $display("FAIL break_entry_frame_error: got %0h expected 1", frame_error); else pass_cnt++;
        pop_entry();
`endif
        send_frame(8, 8, 8'h5A, 0, 0, 0, 1, 1, -1);
        wait_valid(40, lat);
        total_cnt++; if (parallel_data !== 8'h5A) $display("FAIL after_break_data: got %0h expected 5a", parallel_data); else pass_cnt++;
        total_cnt++; if (frame_error !== 1'b0)    $display("FAIL after_break_frame_error: got %0h expected 0", frame_error); else pass_cnt++;
        total_cnt++; if (fifo_level !== 3'd1)     $display("FAIL after_break_level: got %0d expected 1", fifo_level); else pass_cnt++;
        pop_entry();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_even_parity();
        test_two_stop();
        test_odd_parity_error();
        test_false_start_and_glitch();
        test_clamp();
        test_back_to_back();
        test_break();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
